systolic_feeder: RTL
====================

# systolic_feeder

Operand feeder for the 4x4 systolic MAC array. It holds one A and one B matrix of 16-bit Q8.8 operands, loaded through a simple write port. On `start` it pulses an accumulator clear, then streams the operands into the array's west and north edges with the diagonal skew the array requires. It signals `done` once every PE accumulator holds its final C element. It sits directly upstream of the PE grid: lane i of `a_out` drives the A input of PE(i,0), and lane j of `b_out` drives the B input of PE(0,j).

## Interface
- `N`, 4, array dimension (matrices are N x N)
- `W`, 16, operand width (Q8.8)
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr_en`  in  1  write strobe for operand storage
- `wr_sel`  in  1  0 = write matrix A, 1 = write matrix B
- `wr_row`  in  log2(N)  row index of the write
- `wr_col`  in  log2(N)  column index of the write
- `wr_data`  in  W  operand value
- `start`  in  1  begin one matrix-multiply pass
- `acc_clr`  out  1  one-cycle clear pulse to the PE array `rst`
- `a_out`  out  N*W  west-edge operands; lane i = bits [i*W+W-1 : i*W]
- `b_out`  out  N*W  north-edge operands; lane j = bits [j*W+W-1 : j*W]
- `busy`  out  1  high from the CLEAR state through the DRAIN state
- `done`  out  1  one-cycle pulse when the result is final in the array

## Operation
- Storage holds 2*N*N registers of W bits.
- A write occurs only when `wr_en`=1 and `busy`=0; `A[wr_row][wr_col]` or `B[wr_row][wr_col]` is loaded at the edge. Writes while `busy`=1 are dropped.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE. A step counter `t` runs 0..3N-3.
- IDLE / DONE:
  - `start`=1 -> CLEAR; otherwise -> IDLE.
  - DONE lasts exactly one cycle.
  - `start` is ignored in every other state.
- CLEAR (1 cycle):
  - `acc_clr`=1 and all lanes are 0.
  - Next state is STREAM with t=0.
- STREAM (t = 0..2N-2, 7 cycles):
  - `a_out` lane i = `A[i][t-i]` when 0 <= t-i < N, else 0.
  - `b_out` lane j = `B[t-j][j]` when 0 <= t-j < N, else 0.
- DRAIN (t = 2N-1..3N-3, 3 cycles):
  - All lanes are 0.
  - This covers the N-1 forwarding hops, so the product `A[N-1][N-1]*B[N-1][N-1]` lands in PE(N-1,N-1).
- DONE: `done`=1, `busy`=0, all lanes 0.
- Operand outputs are registered, so the lane values above are present during the named cycle, not the cycle after.
- A write and `start` in the same idle cycle: the write is committed, and the pass uses the new value.
- The block does no arithmetic on operands; values pass through bit-exact.

## Timing
- Reset values: `a_out`=0, `b_out`=0, `acc_clr`=0, `busy`=0, `done`=0, FSM=IDLE, t=0, all storage 0.
- `rst` has priority over every input, including mid-pass. The cycle after `rst` is sampled high shows IDLE values, and no `done` is produced for the aborted pass.
- `start` sampled high at edge S:
  - CLEAR in cycle S+1.
  - STREAM in cycles S+2..S+8.
  - DRAIN in cycles S+9..S+11.
  - `done` in cycle S+12.
- Pass length is 3N cycles, CLEAR to DONE inclusive.
- `start` in the DONE cycle is accepted, giving CLEAR in the next cycle. Back-to-back passes have period 3N.
- `acc_clr` is never high outside CLEAR.

## Test plan
- Reset: assert `rst` for 2 cycles with random inputs -> every output is 0; a subsequent read-out pass streams all-zero lanes.
- Skew check: A[i][k]=0x0100+16i+k, B[k][j]=0x0200+16k+j, pulse `start` at edge S:
  - cycle S+2: lane0 a=0x0100, b=0x0200, lanes1-3 zero.
  - cycle S+5: a lane3=0x0130, b lane3=0x0203.
  - cycle S+8: only lane3 nonzero (a=0x0133, b=0x0233).
  - `done` in cycle S+12 only.
- Busy lockout: during STREAM, write 0xFFFF to A[0][0] and pulse `start` -> neither has any effect; the next pass streams the original A[0][0] and `done` appears exactly once at S+12.
- Reset mid-pass: assert `rst` in cycle S+5 -> cycle S+6 shows `busy`=0 and zero lanes; `done` never asserts; storage reads back 0.
- Back-to-back: raise `start` during the `done` cycle -> `acc_clr`=1 on the next cycle, and the second `done` arrives exactly 12 cycles after the first.
- Integration with the 4x4 PE grid: all A=0x0200 (2.0), all B=0x0180 (1.5) -> on `done`, every PE C1 = 0x0C00 (12.0); a second pass with unchanged data again gives 0x0C00, which confirms `acc_clr` works.

Source files
------------

// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN systolic MAC array: stores A and B, then streams them
// into the west/north array edges with diagonal skew, framed by a clear pulse and a done pulse.
module systolic_feeder #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [$clog2(N)-1:0] wr_col,
  input  logic [W-1:0]         wr_data,
  input  logic                 start,
  output logic                 acc_clr,
  output logic [N*W-1:0]       a_out,
  output logic [N*W-1:0]       b_out,
  output logic                 busy,
  output logic                 done
);

  localparam int IW           = $clog2(N);
  localparam int TW           = $clog2(3*N-2);
  localparam int T_STREAM_END = 2*N-2;
  localparam int T_DRAIN_END  = 3*N-3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic             acc_clr_q, acc_clr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N*W-1:0]   a_out_q, a_out_d;
  logic [N*W-1:0]   b_out_q, b_out_d;
  logic [W-1:0]     a_mem_q [N][N];
  logic [W-1:0]     a_mem_d [N][N];
  logic [W-1:0]     b_mem_q [N][N];
  logic [W-1:0]     b_mem_d [N][N];
  logic             lanes_en;
  int               k;

  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    if (wr_en && !busy_q) begin
      if (wr_sel) b_mem_d[wr_row][wr_col] = wr_data;
      else        a_mem_d[wr_row][wr_col] = wr_data;
    end

    // Next-state and next-output logic: every output is computed for the cycle being entered.
    state_d   = state_q;
    t_d       = t_q;
    acc_clr_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    lanes_en  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        t_d = '0;
        if (start) begin
          state_d   = S_CLEAR;
          acc_clr_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d  = S_STREAM;
        t_d      = '0;
        busy_d   = 1'b1;
        lanes_en = 1'b1;
      end
      S_STREAM: begin
        busy_d = 1'b1;
        t_d    = t_q + TW'(1);
        if (t_q == TW'(T_STREAM_END)) state_d = S_DRAIN;
        else                           lanes_en = 1'b1;
      end
      S_DRAIN: begin
        if (t_q == TW'(T_DRAIN_END)) begin
          state_d = S_DONE;
          t_d     = '0;
          done_d  = 1'b1;
        end else begin
          t_d    = t_q + TW'(1);
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        t_d     = '0;
      end
    endcase

    // Lane i carries row i of A (and column i of B) delayed by i steps.
    a_out_d = '0;
    b_out_d = '0;
    k       = 0;
    if (lanes_en) begin
      for (int i = 0; i < N; i++) begin
        k = int'(t_d) - i;
        if (k >= 0 && k < N) begin
          a_out_d[i*W +: W] = a_mem_q[i][k[IW-1:0]];
          b_out_d[i*W +: W] = b_mem_q[k[IW-1:0]][i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      acc_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_out_q   <= '0;
      b_out_q   <= '0;
      a_mem_q   <= '{default: '0};
      b_mem_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      acc_clr_q <= acc_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      a_out_q   <= a_out_d;
      b_out_q   <= b_out_d;
      a_mem_q   <= a_mem_d;
      b_mem_q   <= b_mem_d;
    end
  end

  assign acc_clr = acc_clr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign a_out   = a_out_q;
  assign b_out   = b_out_q;

endmodule
